// File: rtl/divider_pkg.sv
// divider_pkg: shared types and constants
// for the run-time clock divider controller.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/divider_ctrl_counter.sv
// div_counter: W-bit period counter that
// wraps at div-1 and flags the wrap cycle.
module div_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clear,
  input  logic [W-1:0] div,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = en && (count == div - W'(1));

  // count up while enabled, restart on wrap, hold 0 when cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/divider_ctrl.sv
// divider_ctrl: start/stop FSM, divisor handshake
// and glitch-free divided clock generation.
import divider_pkg::*;

module divider_ctrl #(
  parameter int W           = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic [W-1:0] cur_div,
  output logic         running,
  output logic         tick,
  output logic         out_clk
);

  localparam logic [W-1:0] L_MIN = W'(MIN_DIV);
  localparam logic [W-1:0] L_DEF = W'(DEFAULT_DIV);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_cur_div;
  logic [W-1:0] r_pend;
  logic         r_pend_v;
  logic         r_err;
  logic         r_out_clk;
  logic [W-1:0] w_cnt;
  logic [W-1:0] w_cnt_nxt;
  logic [W-1:0] w_div_nxt;
  logic         w_run;
  logic         w_tick;
  logic         w_xfer;
  logic         w_legal;
  logic         w_final;
  logic         w_oclk_nxt;

  assign w_run   = (r_state != IDLE);
  assign w_xfer  = cfg_valid && !r_pend_v;
  assign w_legal = (cfg_div >= L_MIN);
  assign w_final = w_tick && (w_state_nxt == IDLE);

  assign cfg_ready = !r_pend_v;
  assign cfg_err   = r_err;
  assign cur_div   = r_cur_div;
  assign running   = w_run;
  assign tick      = w_tick;
  assign out_clk   = r_out_clk;

  div_counter #(
    .W(W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(reset),
    .en   (w_run),
    .clear(!w_run),
    .div  (r_cur_div),
    .count(w_cnt),
    .wrap (w_tick)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next state: stop beats start; a start while stopping rescues the run
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (start && !stop) w_state_nxt = RUN;
      end
      RUN: begin
        if (stop) w_state_nxt = STOPPING;
      end
      STOPPING: begin
        if (start && !stop) w_state_nxt = RUN;
        else if (w_tick)    w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // divisor for the next cycle: pending lands on a tick, idle writes direct
  always_comb begin
    w_div_nxt = r_cur_div;
    if (w_tick && r_pend_v) begin
      w_div_nxt = r_pend;
    end else if (w_xfer && w_legal && (!w_run || w_final)) begin
      w_div_nxt = cfg_div;
    end
  end

  // decode of the next counter value feeds the out_clk flop
  always_comb begin
    w_cnt_nxt = '0;
    if (w_run && !w_tick) w_cnt_nxt = w_cnt + W'(1);
    w_oclk_nxt = (w_state_nxt != IDLE) &&
                 (w_cnt_nxt >= w_div_nxt - (w_div_nxt >> 1));
  end

  // divisor, pending slot, error pulse and out_clk registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur_div <= L_DEF;
      r_pend    <= '0;
      r_pend_v  <= 1'b0;
      r_err     <= 1'b0;
      r_out_clk <= 1'b0;
    end else begin
      r_cur_div <= w_div_nxt;
      r_err     <= w_xfer && !w_legal;
      r_out_clk <= w_oclk_nxt;
      if (w_tick && r_pend_v) begin
        r_pend_v <= 1'b0;
      end else if (w_xfer && w_legal && w_run && !w_final) begin
        r_pend_v <= 1'b1;
        r_pend   <= cfg_div;
      end
    end
  end

endmodule

// File: tb/tb_divider_ctrl.sv
// tb_divider_ctrl: directed scenario tests
// for the clock divider controller.
module tb_divider_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic        cfg_valid;
  logic [15:0] cfg_div;
  logic        cfg_ready;
  logic        cfg_err;
  logic [15:0] cur_div;
  logic        running;
  logic        tick;
  logic        out_clk;

  int checks = 0;
  int errors = 0;

  divider_ctrl #(
    .W(16),
    .DEFAULT_DIV(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .cur_div  (cur_div),
    .running  (running),
    .tick     (tick),
    .out_clk  (out_clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    int n;
    n = 0;
    stop = 1'b1;
    while (running && n < 20) begin
      cyc();
      n++;
    end
    stop = 1'b0;
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL go_idle running=%b want 0", running);
    end
  endtask

  task automatic load_idle(input logic [15:0] d);
    cfg_valid = 1'b1;
    cfg_div   = d;
    cyc();
    cfg_valid = 1'b0;
    checks++;
    if (cur_div !== d) begin
      errors++;
      $display("FAIL load_idle cur_div=%0d want %0d", cur_div, d);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #23;
    checks++;
    if ({tick, out_clk, running, cfg_err, cfg_ready} !== 5'b00001 ||
        cur_div !== 16'd4) begin
      errors++;
      $display("FAIL reset t/o/r/e/rdy=%b%b%b%b%b div=%0d want 00001 4",
               tick, out_clk, running, cfg_err, cfg_ready, cur_div);
    end
    cyc();
    reset = 1'b1;
    cyc();
    checks++;
    if (running !== 1'b0 || cur_div !== 16'd4 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release run=%b div=%0d rdy=%b want 0 4 1",
               running, cur_div, cfg_ready);
    end
  endtask

  task automatic test_default_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (running !== 1'b1 || tick !== (c % 4 == 3) ||
          out_clk !== (c % 4 >= 2)) begin
        errors++;
        $display("FAIL default c%0d run=%b tick=%b oclk=%b want 1 %b %b",
                 c, running, tick, out_clk, (c % 4 == 3), (c % 4 >= 2));
      end
      cyc();
    end
    go_idle();
  endtask

  task automatic test_odd_div();
    load_idle(16'd5);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 0; c < 15; c++) begin
      checks++;
      if (tick !== (c % 5 == 4) || out_clk !== (c % 5 >= 3)) begin
        errors++;
        $display("FAIL odd c%0d tick=%b oclk=%b want %b %b",
                 c, tick, out_clk, (c % 5 == 4), (c % 5 >= 3));
      end
      cyc();
    end
    go_idle();
  endtask

  task automatic test_mid_update();
    load_idle(16'd4);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_rdy1 rdy=%b want 1", cfg_ready);
    end
    cfg_valid = 1'b1;
    cfg_div   = 16'd6;
    cyc();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0 || cur_div !== 16'd4 || out_clk !== 1'b1) begin
      errors++;
      $display("FAIL mid_c2 rdy=%b div=%0d oclk=%b want 0 4 1",
               cfg_ready, cur_div, out_clk);
    end
    cyc();
    checks++;
    if (tick !== 1'b1 || cfg_ready !== 1'b0 || cur_div !== 16'd4) begin
      errors++;
      $display("FAIL mid_c3 tick=%b rdy=%b div=%0d want 1 0 4",
               tick, cfg_ready, cur_div);
    end
    cyc();
    checks++;
    if (cur_div !== 16'd6 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_apply div=%0d rdy=%b want 6 1", cur_div, cfg_ready);
    end
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (tick !== (c % 6 == 5) || out_clk !== (c % 6 >= 3)) begin
        errors++;
        $display("FAIL mid6 c%0d tick=%b oclk=%b want %b %b",
                 c, tick, out_clk, (c % 6 == 5), (c % 6 >= 3));
      end
      cyc();
    end
    go_idle();
  endtask

  task automatic test_illegal();
    logic [15:0] bad [2];
    bad[0] = 16'd0;
    bad[1] = 16'd1;
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 1) begin
        start = 1'b1;
        cyc();
        start = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        cfg_valid = 1'b1;
        cfg_div   = bad[i];
        cyc();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_err !== 1'b1 || cur_div !== 16'd6 || cfg_ready !== 1'b1) begin
          errors++;
          $display("FAIL illegal p%0d v%0d err=%b div=%0d rdy=%b want 1 6 1",
                   ph, bad[i], cfg_err, cur_div, cfg_ready);
        end
        cyc();
        checks++;
        if (cfg_err !== 1'b0 || cur_div !== 16'd6) begin
          errors++;
          $display("FAIL illegal_clr p%0d err=%b div=%0d want 0 6",
                   ph, cfg_err, cur_div);
        end
      end
    end
    go_idle();
  endtask

  task automatic test_races();
    load_idle(16'd4);
    start = 1'b1;
    stop  = 1'b1;
    cyc();
    cyc();
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL both_idle run=%b want 0", running);
    end
    stop = 1'b0;
    cyc();
    start = 1'b0;
    stop  = 1'b1;
    cyc();
    stop = 1'b0;
    for (int c = 1; c < 4; c++) begin
      checks++;
      if (running !== 1'b1 || tick !== (c == 3)) begin
        errors++;
        $display("FAIL stop c%0d run=%b tick=%b want 1 %b",
                 c, running, tick, (c == 3));
      end
      cyc();
    end
    checks++;
    if (running !== 1'b0 || tick !== 1'b0 || out_clk !== 1'b0) begin
      errors++;
      $display("FAIL stop_end run=%b tick=%b oclk=%b want 0 0 0",
               running, tick, out_clk);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    stop  = 1'b1;
    cyc();
    stop  = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 2; c < 9; c++) begin
      checks++;
      if (running !== 1'b1 || tick !== (c % 4 == 3)) begin
        errors++;
        $display("FAIL rescue c%0d run=%b tick=%b want 1 %b",
                 c, running, tick, (c % 4 == 3));
      end
      cyc();
    end
    go_idle();
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cfg_valid = 1'b1;
    cfg_div   = 16'd7;
    cyc();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0 || out_clk !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre rdy=%b oclk=%b want 0 1", cfg_ready, out_clk);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (running !== 1'b0 || out_clk !== 1'b0 || tick !== 1'b0 ||
        cfg_ready !== 1'b1 || cur_div !== 16'd4) begin
      errors++;
      $display("FAIL arst run=%b oclk=%b tick=%b rdy=%b div=%0d want 0 0 0 1 4",
               running, out_clk, tick, cfg_ready, cur_div);
    end
    cyc();
    reset = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (cur_div !== 16'd4 || tick !== (c % 4 == 3)) begin
        errors++;
        $display("FAIL arst_after c%0d div=%0d tick=%b want 4 %b",
                 c, cur_div, tick, (c % 4 == 3));
      end
      cyc();
    end
    go_idle();
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    test_reset();
    test_default_start();
    test_odd_div();
    test_mid_update();
    test_illegal();
    test_races();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_ctrl.md
# divider_ctrl

Run-time controller for the programmable clock divider in the lab clocking path. It accepts divisor updates over a valid/ready handshake and starts and stops the divided clock on command. New divisors take effect only on period boundaries, so `out_clk` never produces a runt or stretched pulse. It drives a divided square wave (`out_clk`) and a one-cycle period strobe (`tick`) to downstream blocks.

## Interface
- `W`, 16: divisor and counter width.
- `DEFAULT_DIV`, 4: divisor loaded at reset; must satisfy 2 ≤ `DEFAULT_DIV` ≤ 2^W−1.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `start`  in  1  level-sampled start request.
- `stop`  in  1  level-sampled stop request.
- `cfg_valid`  in  1  divisor update offered.
- `cfg_div`  in  W  offered divisor.
- `cfg_ready`  out  1  update can be accepted this cycle.
- `cfg_err`  out  1  one-cycle pulse: rejected divisor.
- `cur_div`  out  W  divisor currently in force.
- `running`  out  1  state is RUN or STOPPING.
- `tick`  out  1  one-cycle pulse in the last cycle of each period.
- `out_clk`  out  1  divided clock.

## Operation
- States:
  - IDLE: counter held at 0, `out_clk`=0, `tick`=0.
  - RUN: counter counts 0..`cur_div`−1 and wraps.
  - STOPPING: RUN behaviour, then exits at the end of the current period.
- Transitions:
  - IDLE→RUN on `start`=1 and `stop`=0. If both are 1, `stop` wins and the state stays IDLE.
  - RUN→STOPPING on `stop`. `start` is ignored in RUN.
  - STOPPING→RUN on `start`=1 and `stop`=0. The period is not restarted; the counter continues.
  - STOPPING→IDLE in the tick cycle.
- Handshake:
  - A transfer occurs when `cfg_valid` and `cfg_ready` are both 1.
  - `cfg_ready` = NOT pending_valid. It is combinational from a flop, with no path from `cfg_valid`.
- Accepted divisor < 2:
  - It is dropped; `cur_div` and pending are unchanged.
  - `cfg_err`=1 in the following cycle.
- Accepted divisor ≥ 2 in IDLE: written to `cur_div`, visible in the next cycle. Pending is unused.
- Accepted divisor ≥ 2 in RUN or STOPPING:
  - It is stored in pending, and `cfg_ready` drops in the next cycle.
  - At the next tick cycle, pending is copied to `cur_div` and cleared. The following period uses the new value, and `cfg_ready` returns in the next cycle.
- Transfer in the same cycle as a tick with pending empty: stored, then applied at the *next* tick, not the current one.
- A pending value still held on the STOPPING→IDLE tick is applied on that tick.
- `tick` = running AND (counter == `cur_div`−1).
- `out_clk` = running AND (counter ≥ `cur_div` − `cur_div`/2), using integer division:
  - the high time is floor(div/2) cycles, at the end of the period;
  - `out_clk` is driven from a flop loaded with the decode of the next counter value, and is glitch-free.
- Arithmetic:
  - Counter is W bits.
  - The compare uses `cur_div`−1, which cannot underflow because `cur_div` ≥ 2 always holds.
  - No wider intermediate values are needed.

## Timing
- Reset (asynchronous assert, synchronous release) gives:
  - state IDLE, counter 0, `cur_div`=`DEFAULT_DIV`, pending empty;
  - `tick`=0, `out_clk`=0, `running`=0, `cfg_err`=0, `cfg_ready`=1.
- `start` sampled at edge k:
  - `running`=1 and counter=0 in cycle k;
  - first `tick` in cycle k+`cur_div`−1;
  - ticks then repeat every `cur_div` cycles.
- `stop` sampled in RUN: the current period completes. `running`=0 in the cycle after the tick.
- `cfg_err` latency: 1 cycle after the handshake.
- Reset asserted mid-period: all state is forced to reset values immediately. Pending updates are lost.

## Structure
- Package `divider_pkg` holds:
  - `state_t` enum (IDLE, RUN, STOPPING);
  - `MIN_DIV`=2.
- Sub-module `div_counter` is the W-bit wrap counter. It has these ports:
  - `en`;
  - `div`;
  - `clear`;
  - `count`;
  - `wrap` (the tick decode).
- The controller instantiates `div_counter` and owns the FSM, the pending register, the handshake and the `out_clk` flop.

## Test plan
- **Reset, then start with default divisor:** release reset; `start` pulse at edge 0.
  - `tick` at cycles 3, 7, 11.
  - `out_clk` high in cycles 2–3, 6–7.
- **Odd divisor in IDLE:** load `cfg_div`=5, then start.
  - `tick` every 5 cycles.
  - `out_clk` high 2 cycles, low 3 cycles.
- **Mid-run update:** running with div=4; load 6 at counter=1.
  - `cfg_ready` low until the tick.
  - Next period is 6 cycles long; `cur_div`=6 is visible after that tick.
  - No short `out_clk` pulse.
- **Illegal divisors:** `cfg_div`=0 and `cfg_div`=1 in both IDLE and RUN.
  - `cfg_err` pulses one cycle after each.
  - `cur_div` is unchanged.
- **Stop/start races:**
  - `start`+`stop` together in IDLE: stays IDLE.
  - `stop` at counter=0 with div=4: final tick 3 cycles later, then `running`=0.
  - `start` during STOPPING: running continues with no gap.
- **Async reset mid-run:** assert `reset` low at counter=2 with an update pending.
  - Outputs go to reset values immediately.
  - `cur_div`=4 after release.
